// File: rtl/rf_pkg.sv
// Shared defaults and dump-state encoding for the decode-stage register file.
package rf_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_e;
endpackage

// File: rtl/rf_dump_fsm.sv
// Dump sequencer: streams every register as an (idx, data) beat, 1 cycle from start to first beat.
// Beats are snapshotted on load and held unchanged while valid && !ready.
module rf_dump_fsm
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_idx,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_done
);
  localparam int DEPTH = 2 ** ADDR_W;

  dump_state_e       r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              w_last;

  assign w_last = (r_idx == ADDR_W'(DEPTH - 1));

  // The top returns the bypassed read value of this address; it is the next beat's index.
  assign o_rd_addr = (r_state == SEND) ? r_idx + ADDR_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= SEND;
            r_idx   <= '0;
            r_data  <= i_rd_data;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        SEND: begin
          if (i_ready) begin
            if (w_last) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx  <= r_idx + ADDR_W'(1);
              r_data <= i_rd_data;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_idx   = r_idx;
  assign o_data  = r_data;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
endmodule

// File: rtl/reg_file_dump.sv
// 2R1W register file with write-to-read bypass, optional zero register and a streaming dump port.
// Reads: 1-cycle registered latency, never stalled; dump beats hold while dump_ready is low.
module reg_file_dump
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;

  logic              w_we_eff;
  logic [ADDR_W-1:0] w_dump_addr;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_dump_val;

  assign w_we_eff = we && !(HAS_ZERO && (wr_addr == '0));

  // All three read paths see the same-cycle write so no consumer observes stale data.
  assign w_rs_val = (HAS_ZERO && rs_addr == '0) ? '0 :
                    (w_we_eff && wr_addr == rs_addr) ? wr_data : r_mem[rs_addr];
  assign w_rt_val = (HAS_ZERO && rt_addr == '0) ? '0 :
                    (w_we_eff && wr_addr == rt_addr) ? wr_data : r_mem[rt_addr];
  assign w_dump_val = (HAS_ZERO && w_dump_addr == '0) ? '0 :
                      (w_we_eff && wr_addr == w_dump_addr) ? wr_data : r_mem[w_dump_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we_eff) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs_data <= '0;
      r_rt_data <= '0;
    end else begin
      r_rs_data <= w_rs_val;
      r_rt_data <= w_rt_val;
    end
  end

  assign rs_data = r_rs_data;
  assign rt_data = r_rt_data;

  rf_dump_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dump_fsm (
    .clk       (clk),
    .reset     (reset),
    .i_start   (dump_start),
    .i_ready   (dump_ready),
    .i_rd_data (w_dump_val),
    .o_rd_addr (w_dump_addr),
    .o_valid   (dump_valid),
    .o_idx     (dump_idx),
    .o_data    (dump_data),
    .o_busy    (dump_busy),
    .o_done    (dump_done)
  );
endmodule

// File: tb/tb_reg_file_dump.sv
// Bench for reg_file_dump: behavioural model plus per-cycle compare, directed and random stimulus.
module tb_reg_file_dump;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rs_addr = '0, rt_addr = '0, wr_addr = '0;
  logic          we = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          dump_start = 1'b0, dump_ready = 1'b0;

  logic [DW-1:0] rs_data, rt_data, dump_data;
  logic [AW-1:0] dump_idx;
  logic          dump_valid, dump_busy, dump_done;

  logic [DW-1:0] z_rs_data, z_rt_data, z_dump_data;
  logic [AW-1:0] z_dump_idx;
  logic          z_dump_valid, z_dump_busy, z_dump_done;

  always #5 clk = ~clk;

  reg_file_dump #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .dump_start(dump_start), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  reg_file_dump #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) u_dut_nz (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(z_rs_data), .rt_data(z_rt_data), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .dump_start(dump_start), .dump_ready(dump_ready),
    .dump_valid(z_dump_valid), .dump_idx(z_dump_idx), .dump_data(z_dump_data),
    .dump_busy(z_dump_busy), .dump_done(z_dump_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  int n_done   = 0;
  int bidx[$];
  logic [DW-1:0] bdat[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference model: registers as arrays, dump as "which beat is on offer".
  logic [DW-1:0] m_mem1[DEPTH];
  logic [DW-1:0] m_mem0[DEPTH];
  logic [DW-1:0] e_rs1, e_rt1, e_rs0, e_rt0, m_val;
  bit            m_send, m_done;
  int            m_idx;

  function automatic logic [DW-1:0] rdval(input bit zero, input int a);
    if (zero && a == 0) return '0;
    if (we && !(zero && wr_addr == 0) && int'(wr_addr) == a) return wr_data;
    return zero ? m_mem1[a] : m_mem0[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem1[i] = '0;
        m_mem0[i] = '0;
      end
      e_rs1 = '0; e_rt1 = '0; e_rs0 = '0; e_rt0 = '0;
      m_send = 0; m_done = 0; m_idx = 0; m_val = '0;
    end else begin
      e_rs1 = rdval(1, int'(rs_addr));
      e_rt1 = rdval(1, int'(rt_addr));
      e_rs0 = rdval(0, int'(rs_addr));
      e_rt0 = rdval(0, int'(rt_addr));
      if (m_send) begin
        if (dump_ready) begin
          if (m_idx == DEPTH - 1) begin
            m_send = 0;
            m_done = 1;
          end else begin
            m_idx = m_idx + 1;
            m_val = rdval(1, m_idx);
          end
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (dump_start) begin
        m_send = 1;
        m_idx  = 0;
        m_val  = rdval(1, 0);
      end
      if (we) begin
        if (wr_addr != 0) m_mem1[wr_addr] = wr_data;
        m_mem0[wr_addr] = wr_data;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rs_data", rs_data, e_rs1);
      chk("rt_data", rt_data, e_rt1);
      chk("nz_rs_data", z_rs_data, e_rs0);
      chk("nz_rt_data", z_rt_data, e_rt0);
      chk("dump_valid", {31'd0, dump_valid}, {31'd0, m_send});
      chk("dump_busy", {31'd0, dump_busy}, {31'd0, (m_send || m_done)});
      chk("dump_done", {31'd0, dump_done}, {31'd0, m_done});
      chk("dump_idx", {27'd0, dump_idx}, DW'(m_idx));
      chk("dump_data", dump_data, m_val);
      if (dump_valid && dump_ready) begin
        bidx.push_back(int'(dump_idx));
        bdat.push_back(dump_data);
      end
      if (dump_done) n_done++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_beats(input string name, input bit with_data);
    int errs;
    errs = 0;
    chk({name, "_count"}, DW'(bidx.size()), DW'(DEPTH));
    for (int i = 0; i < bidx.size() && i < DEPTH; i++) begin
      if (bidx[i] != i) errs++;
      if (with_data && bdat[i] !== DW'(i * 3)) errs++;
    end
    chk({name, "_seq"}, DW'(errs), '0);
  endtask

  initial begin
    int cyc;
    int k;
    reset = 1'b1;
    step();
    step();
    chk_en = 1;
    chk("rst_rs", rs_data, '0);
    chk("rst_valid", {31'd0, dump_valid}, '0);
    chk("rst_busy", {31'd0, dump_busy}, '0);
    reset = 1'b0;

    rs_addr = 5; rt_addr = 31;
    step();
    chk("read_rs5", rs_data, '0);
    chk("read_rt31", rt_data, '0);

    we = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
    step();
    we = 0; rs_addr = 0;
    step();
    chk("zero_reg_on", rs_data, 32'h0000_0000);
    chk("zero_reg_off", z_rs_data, 32'hFFFF_FFFF);

    we = 1; wr_addr = 7; wr_data = 32'h1234_5678; rs_addr = 7; rt_addr = 7;
    step();
    we = 0;
    chk("bypass_rs", rs_data, 32'h1234_5678);
    chk("bypass_rt", rt_data, 32'h1234_5678);
    step();
    step();
    chk("after_write_rs", rs_data, 32'h1234_5678);

    for (int i = 0; i < DEPTH; i++) begin
      we = 1; wr_addr = AW'(i); wr_data = DW'(i * 3);
      step();
    end
    we = 0;

    bidx.delete(); bdat.delete(); n_done = 0;
    dump_ready = 1; dump_start = 1;
    step();
    dump_start = 0;
    cyc = 1;
    chk("first_beat_valid", {31'd0, dump_valid}, 32'd1);
    chk("first_beat_idx", {27'd0, dump_idx}, 32'd0);
    while (!dump_done && cyc < 100) begin
      step();
      cyc++;
    end
    if (cyc >= 100) fail_now("full_dump_done");
    chk("done_cycle", DW'(cyc), 32'd33);
    step();
    chk("busy_after_done", {31'd0, dump_busy}, '0);
    check_beats("full_dump", 1);
    chk("full_dump_done_cnt", DW'(n_done), 32'd1);

    bidx.delete(); bdat.delete(); n_done = 0;
    dump_ready = 0; dump_start = 1;
    step();
    dump_start = 0;
    k = 0;
    while (m_send && k < 400) begin
      dump_ready = (k % 4 == 0) || (k % 4 == 3);
      we = !dump_ready;
      wr_addr = AW'(m_idx);
      wr_data = 32'hDEAD_0000 + DW'(m_idx);
      step();
      k++;
    end
    we = 0; dump_ready = 1;
    if (k >= 400) fail_now("bp_dump_end");
    step();
    step();
    check_beats("bp_dump", 1);
    chk("bp_done_cnt", DW'(n_done), 32'd1);
    rs_addr = 5;
    step();
    chk("bp_write_landed", rs_data, 32'hDEAD_0005);

    n_done = 0;
    dump_ready = 1; dump_start = 1;
    step();
    dump_start = 0;
    k = 0;
    while (m_idx < 10 && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) fail_now("reach_beat10");
    dump_start = 1;
    step();
    dump_start = 0;
    chk("start_ignored_idx", {27'd0, dump_idx}, 32'd11);
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_busy", {31'd0, dump_busy}, '0);
    chk("mid_rst_idx", {27'd0, dump_idx}, '0);
    rs_addr = 7;
    for (int i = 0; i < 5; i++) step();
    chk("mid_rst_no_done", DW'(n_done), '0);
    chk("mid_rst_mem_clear", rs_data, '0);

    bidx.delete(); bdat.delete(); n_done = 0;
    dump_start = 1;
    step();
    dump_start = 0;
    step();
    dump_start = 1;
    step();
    dump_start = 0;
    for (int i = 0; i < 60; i++) step();
    chk("restart_done_cnt", DW'(n_done), 32'd1);
    chk("restart_beats", DW'(bidx.size()), DW'(DEPTH));

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(199) == 0);
      we         = $urandom_range(1);
      wr_addr    = AW'($urandom);
      wr_data    = $urandom;
      rs_addr    = AW'($urandom);
      rt_addr    = AW'($urandom);
      dump_start = ($urandom_range(15) == 0);
      dump_ready = ($urandom_range(2) != 0);
      step();
    end
    reset = 0; we = 0; dump_start = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
